csr_file: RTL and testbench

Machine-mode control and status register file for the RV32I core. Instruction-side Zicsr accesses (CSRRW/CSRRS/CSRRC and immediate forms) read and write it from the execute stage. The trap controller uses it to record mepc and mcause and to fetch mtvec and mepc. It returns read data combinationally from a single shared read mux, so both the trap sequencer and the CSR instructions see a value in the same cycle they present an address.

---
 rtl/csr_file.sv | 162 ++++++++++++++++
 tb/tb_csr_file.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/csr_file.sv
// Machine-mode CSR file for the RV32I core: Zicsr instruction port, trap port, one shared read mux.
// Optional feature: define CSR_COUNTERS_EN to add mcycle/minstret and their cycle/instret shadows.
module csr_file #(
  parameter logic [31:0] MHARTID     = 32'h0,
  parameter logic [31:0] MTVEC_RESET = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [11:0] csr_read_address,
  input  logic [1:0]  csr_op,
  input  logic [31:0] csr_src,
  input  logic        csr_inst_write_enable,
  input  logic [11:0] csr_trap_address,
  input  logic [31:0] csr_trap_write_data,
  input  logic        csr_write_enable,
  input  logic        trap_done,
  input  logic        instr_retired,
  output logic [31:0] csr_read_data,
  output logic        csr_illegal
);

  localparam logic [11:0] ADDR_MSTATUS   = 12'h300;
  localparam logic [11:0] ADDR_MISA      = 12'h301;
  localparam logic [11:0] ADDR_MTVEC     = 12'h305;
  localparam logic [11:0] ADDR_MSCRATCH  = 12'h340;
  localparam logic [11:0] ADDR_MEPC      = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE    = 12'h342;
  localparam logic [11:0] ADDR_MVENDORID = 12'hF11;
  localparam logic [11:0] ADDR_MARCHID   = 12'hF12;
  localparam logic [11:0] ADDR_MIMPID    = 12'hF13;
  localparam logic [11:0] ADDR_MHARTID   = 12'hF14;
  localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
  localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
  localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;
  localparam logic [11:0] ADDR_CYCLE     = 12'hC00;
  localparam logic [11:0] ADDR_CYCLEH    = 12'hC80;
  localparam logic [11:0] ADDR_INSTRET   = 12'hC02;
  localparam logic [11:0] ADDR_INSTRETH  = 12'hC82;

  localparam logic [31:0] MISA_VALUE = 32'h4000_0100;

  logic        mstatus_mie;
  logic        mstatus_mpie;
  logic [31:2] mtvec_base;
  logic [31:0] mscratch;
  logic [31:2] mepc_base;
  logic [31:0] mcause;

  logic        trap_owner;
  logic [11:0] sel_address;
  logic        implemented;
  logic        read_only;
  logic        inst_write_request;
  logic        inst_write;
  logic [31:0] new_value;
  logic        write_en;
  logic [11:0] write_address;
  logic [31:0] write_data;

`ifdef CSR_COUNTERS_EN
  logic [63:0] mcycle;
  logic [63:0] minstret;
`else
  wire unused_instr_retired = instr_retired;
`endif

  assign trap_owner  = !trap_done || (csr_trap_address != 12'h000);
  assign sel_address = trap_owner ? csr_trap_address : csr_read_address;

  always_comb begin
    csr_read_data = 32'h0;
    implemented   = 1'b1;
    case (sel_address)
      ADDR_MSTATUS:   csr_read_data = {19'b0, 2'b11, 3'b0, mstatus_mpie, 3'b0, mstatus_mie, 3'b0};
      ADDR_MISA:      csr_read_data = MISA_VALUE;
      ADDR_MTVEC:     csr_read_data = {mtvec_base, 2'b00};
      ADDR_MSCRATCH:  csr_read_data = mscratch;
      ADDR_MEPC:      csr_read_data = {mepc_base, 2'b00};
      ADDR_MCAUSE:    csr_read_data = mcause;
      ADDR_MVENDORID: csr_read_data = 32'h0;
      ADDR_MARCHID:   csr_read_data = 32'h0;
      ADDR_MIMPID:    csr_read_data = 32'h0;
      ADDR_MHARTID:   csr_read_data = MHARTID;
`ifdef CSR_COUNTERS_EN
      ADDR_MCYCLE,   ADDR_CYCLE:    csr_read_data = mcycle[31:0];
      ADDR_MCYCLEH,  ADDR_CYCLEH:   csr_read_data = mcycle[63:32];
      ADDR_MINSTRET, ADDR_INSTRET:  csr_read_data = minstret[31:0];
      ADDR_MINSTRETH, ADDR_INSTRETH: csr_read_data = minstret[63:32];
`endif
      default:        implemented = 1'b0;
    endcase
  end

  // "old" for set/clear is the value on the read port, i.e. the stored value before masking on write.
  always_comb begin
    case (csr_op)
      2'b01:   new_value = csr_src;
      2'b10:   new_value = csr_read_data | csr_src;
      2'b11:   new_value = csr_read_data & ~csr_src;
      default: new_value = csr_read_data;
    endcase
  end

  assign read_only          = (sel_address[11:10] == 2'b11) || (sel_address == ADDR_MISA);
  assign inst_write_request = csr_inst_write_enable && (csr_op != 2'b00);
  assign csr_illegal        = !trap_owner && (!implemented || (inst_write_request && read_only));
  assign inst_write         = !trap_owner && inst_write_request && !csr_illegal;

  // Trap write has priority; the instruction write is only taken when the trap port is not writing.
  assign write_en      = csr_write_enable || inst_write;
  assign write_address = csr_write_enable ? csr_trap_address : sel_address;
  assign write_data    = csr_write_enable ? csr_trap_write_data : new_value;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mstatus_mie  <= 1'b0;
      mstatus_mpie <= 1'b0;
      mtvec_base   <= MTVEC_RESET[31:2];
      mscratch     <= 32'h0;
      mepc_base    <= 30'h0;
      mcause       <= 32'h0;
    end else if (write_en) begin
      case (write_address)
        ADDR_MSTATUS: begin
          mstatus_mie  <= write_data[3];
          mstatus_mpie <= write_data[7];
        end
        ADDR_MTVEC:    mtvec_base <= write_data[31:2];
        ADDR_MSCRATCH: mscratch   <= write_data;
        ADDR_MEPC:     mepc_base  <= write_data[31:2];
        ADDR_MCAUSE:   mcause     <= write_data;
        default: ;
      endcase
    end
  end

`ifdef CSR_COUNTERS_EN
  // A write to one half replaces it, holds the other half and suppresses that cycle's increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mcycle   <= 64'h0;
      minstret <= 64'h0;
    end else begin
      if (write_en && write_address == ADDR_MCYCLE)
        mcycle <= {mcycle[63:32], write_data};
      else if (write_en && write_address == ADDR_MCYCLEH)
        mcycle <= {write_data, mcycle[31:0]};
      else
        mcycle <= mcycle + 64'd1;

      if (write_en && write_address == ADDR_MINSTRET)
        minstret <= {minstret[63:32], write_data};
      else if (write_en && write_address == ADDR_MINSTRETH)
        minstret <= {write_data, minstret[31:0]};
      else if (instr_retired)
        minstret <= minstret + 64'd1;
    end
  end
`endif

endmodule

// File: tb/tb_csr_file.sv
// Directed self-checking bench for csr_file; counter checks are compiled in when CSR_COUNTERS_EN is defined.
module tb_csr_file;

  localparam logic [31:0] HART_ID   = 32'h0000_0005;
  localparam logic [31:0] MTVEC_RST = 32'h0000_0100;

  logic        clk;
  logic        reset;
  logic [11:0] csr_read_address;
  logic [1:0]  csr_op;
  logic [31:0] csr_src;
  logic        csr_inst_write_enable;
  logic [11:0] csr_trap_address;
  logic [31:0] csr_trap_write_data;
  logic        csr_write_enable;
  logic        trap_done;
  logic        instr_retired;
  logic [31:0] csr_read_data;
  logic        csr_illegal;

  int checks = 0;
  int errors = 0;

  csr_file #(.MHARTID(HART_ID), .MTVEC_RESET(MTVEC_RST)) dut (
    .clk(clk),
    .reset(reset),
    .csr_read_address(csr_read_address),
    .csr_op(csr_op),
    .csr_src(csr_src),
    .csr_inst_write_enable(csr_inst_write_enable),
    .csr_trap_address(csr_trap_address),
    .csr_trap_write_data(csr_trap_write_data),
    .csr_write_enable(csr_write_enable),
    .trap_done(trap_done),
    .instr_retired(instr_retired),
    .csr_read_data(csr_read_data),
    .csr_illegal(csr_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  // Inputs change 1ns after a rising edge so the next edge sees them settled.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [11:0] addr, input logic [1:0] op,
                               input logic [31:0] src, input logic we);
    csr_read_address      = addr;
    csr_op                = op;
    csr_src               = src;
    csr_inst_write_enable = we;
    #1;
  endtask

  task automatic readCheck(input string tag, input logic [11:0] addr,
                           input logic [31:0] exp_data, input logic exp_illegal);
    applyStimulus(addr, 2'b00, 32'h0, 1'b0);
    checkOutput(tag, csr_read_data, exp_data);
    checkOutput({tag, "_ill"}, {31'b0, csr_illegal}, {31'b0, exp_illegal});
  endtask

  task automatic instWrite(input logic [11:0] addr, input logic [1:0] op, input logic [31:0] src);
    applyStimulus(addr, op, src, 1'b1);
    tick();
    csr_inst_write_enable = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    csr_read_address = 12'h0; csr_op = 2'b00; csr_src = 32'h0; csr_inst_write_enable = 1'b0;
    csr_trap_address = 12'h0; csr_trap_write_data = 32'h0; csr_write_enable = 1'b0;
    trap_done = 1'b1; instr_retired = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();

    readCheck("rst_mstatus", 12'h300, 32'h0000_1800, 1'b0);
    readCheck("rst_misa", 12'h301, 32'h4000_0100, 1'b0);
    readCheck("rst_mtvec", 12'h305, MTVEC_RST, 1'b0);
    readCheck("rst_mscratch", 12'h340, 32'h0, 1'b0);
    readCheck("rst_mhartid", 12'hF14, HART_ID, 1'b0);
    readCheck("rst_mvendorid", 12'hF11, 32'h0, 1'b0);

    instWrite(12'h305, 2'b01, 32'h8000_0103);
    readCheck("csrrw_mtvec", 12'h305, 32'h8000_0100, 1'b0);
    instWrite(12'h300, 2'b10, 32'h0000_0008);
    readCheck("csrrs_mstatus", 12'h300, 32'h0000_1808, 1'b0);
    instWrite(12'h300, 2'b11, 32'h0000_0008);
    readCheck("csrrc_mstatus", 12'h300, 32'h0000_1800, 1'b0);
    instWrite(12'h300, 2'b01, 32'hFFFF_FFFF);
    readCheck("mstatus_mask", 12'h300, 32'h0000_1888, 1'b0);
    instWrite(12'h300, 2'b01, 32'h0);
    readCheck("mstatus_clr", 12'h300, 32'h0000_1800, 1'b0);
    instWrite(12'h340, 2'b01, 32'hA5A5_A5A5);
    instWrite(12'h340, 2'b10, 32'h0F00_0000);
    readCheck("csrrs_mscratch", 12'h340, 32'hAFA5_A5A5, 1'b0);
    instWrite(12'h340, 2'b11, 32'h0000_00FF);
    readCheck("csrrc_mscratch", 12'h340, 32'hAFA5_A500, 1'b0);

    // Trap sequence with a competing instruction write to mscratch on the mepc edge.
    trap_done = 1'b0;
    csr_trap_address = 12'h341; csr_trap_write_data = 32'h0000_1236; csr_write_enable = 1'b1;
    applyStimulus(12'h340, 2'b01, 32'hDEAD_BEEF, 1'b1);
    checkOutput("trap_no_bypass", csr_read_data, 32'h0);
    checkOutput("trap_ill", {31'b0, csr_illegal}, 32'h0);
    tick();
    csr_inst_write_enable = 1'b0;
    csr_trap_address = 12'h342; csr_trap_write_data = 32'h0000_000B;
    #1;
    checkOutput("mcause_before", csr_read_data, 32'h0);
    tick();
    csr_write_enable = 1'b0;
    csr_trap_address = 12'h305;
    #1;
    checkOutput("trap_mtvec", csr_read_data, 32'h8000_0100);
    csr_trap_address = 12'h301; csr_trap_write_data = 32'h0; csr_write_enable = 1'b1;
    tick();
    csr_write_enable = 1'b0;
    #1;
    checkOutput("trap_misa_ro", csr_read_data, 32'h4000_0100);
    trap_done = 1'b1;
    csr_trap_address = 12'h341;
    #1;
    checkOutput("trap_addr_owner", csr_read_data, 32'h0000_1234);
    csr_trap_address = 12'h0;
    readCheck("mepc", 12'h341, 32'h0000_1234, 1'b0);
    readCheck("mcause", 12'h342, 32'h0000_000B, 1'b0);
    readCheck("mscratch_kept", 12'h340, 32'hAFA5_A500, 1'b0);

    // Illegal instruction-side accesses.
    applyStimulus(12'hF14, 2'b01, 32'h1234, 1'b1);
    checkOutput("ill_mhartid", {31'b0, csr_illegal}, 32'h1);
    tick();
    csr_inst_write_enable = 1'b0;
    readCheck("mhartid_kept", 12'hF14, HART_ID, 1'b0);
    applyStimulus(12'h7C0, 2'b01, 32'h1234, 1'b1);
    checkOutput("ill_7c0", {31'b0, csr_illegal}, 32'h1);
    tick();
    csr_inst_write_enable = 1'b0;
    readCheck("unimpl_7c0", 12'h7C0, 32'h0, 1'b1);
    applyStimulus(12'h301, 2'b01, 32'h0, 1'b1);
    checkOutput("ill_misa", {31'b0, csr_illegal}, 32'h1);
    applyStimulus(12'hF14, 2'b10, 32'h0, 1'b0);
    checkOutput("csrrs_x0_data", csr_read_data, HART_ID);
    checkOutput("csrrs_x0_ill", {31'b0, csr_illegal}, 32'h0);
    applyStimulus(12'hF14, 2'b00, 32'hFFFF_FFFF, 1'b1);
    checkOutput("op00_ill", {31'b0, csr_illegal}, 32'h0);
    tick();
    csr_inst_write_enable = 1'b0;

`ifdef CSR_COUNTERS_EN
    instWrite(12'hB00, 2'b01, 32'hFFFF_FFFF);
    instWrite(12'hB80, 2'b01, 32'h0);
    readCheck("mcycleh_held", 12'hB80, 32'h0, 1'b0);
    readCheck("mcycle_held", 12'hB00, 32'hFFFF_FFFF, 1'b0);
    tick();
    readCheck("mcycleh_carry", 12'hB80, 32'h1, 1'b0);
    readCheck("mcycle_wrap", 12'hB00, 32'h0, 1'b0);
    readCheck("cycleh_shadow", 12'hC80, 32'h1, 1'b0);
    applyStimulus(12'hC00, 2'b01, 32'h0, 1'b1);
    checkOutput("ill_cycle_wr", {31'b0, csr_illegal}, 32'h1);
    csr_inst_write_enable = 1'b0;
    readCheck("minstret_zero", 12'hB02, 32'h0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      instr_retired = 1'b1;
      tick();
      instr_retired = 1'b0;
      tick();
    end
    readCheck("minstret_3", 12'hB02, 32'h3, 1'b0);
    readCheck("instret_3", 12'hC02, 32'h3, 1'b0);
`else
    readCheck("no_mcycle", 12'hB00, 32'h0, 1'b1);
    readCheck("no_cycle", 12'hC00, 32'h0, 1'b1);
    readCheck("no_minstreth", 12'hB82, 32'h0, 1'b1);
`endif

    // Reset arrives during the mcause write cycle of a new trap sequence.
    trap_done = 1'b0;
    csr_trap_address = 12'h341; csr_trap_write_data = 32'h0000_2000; csr_write_enable = 1'b1;
    tick();
    csr_trap_address = 12'h342; csr_trap_write_data = 32'h0000_0007;
    #2;
    reset = 1'b1;
    #1;
    checkOutput("rst_async", csr_read_data, 32'h0);
    tick();
    csr_write_enable = 1'b0; trap_done = 1'b1; csr_trap_address = 12'h0;
    reset = 1'b0;
    #1;
    readCheck("post_rst_mepc", 12'h341, 32'h0, 1'b0);
    readCheck("post_rst_mcause", 12'h342, 32'h0, 1'b0);
    readCheck("post_rst_mtvec", 12'h305, MTVEC_RST, 1'b0);
    readCheck("post_rst_mscratch", 12'h340, 32'h0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
